hazard_forwarding_unit: RTL and testbench

//  Pipeline hazard controller between IF/ID and EX/MEM/WB. Tracks destination tags of the

---
 rtl/hazard_forwarding_unit.sv | 129 ++++++++++++
 tb/tb_hazard_forwarding_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forwarding_unit.sv
// rtl/hazard_forwarding_unit.sv - ID operand forwarding, load-use stall and branch squash control
// Optional perf counters enabled by defining HAZ_PERF_CNT_EN.
module hazard_forwarding_unit #(
  parameter int AW              = 5,
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_W           = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [AW-1:0]    ID_RA,
  input  logic [AW-1:0]    ID_RB,
  input  logic             ID_USE_A,
  input  logic             ID_USE_B,
  input  logic [AW-1:0]    ID_RD,
  input  logic             ID_RF_LE,
  input  logic             ID_L,
  input  logic             EX_J,
  output logic [1:0]       A_S,
  output logic [1:0]       B_S,
  output logic             PC_LE,
  output logic             IFID_LE,
  output logic             IFID_FLUSH,
  output logic             CU_S,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  localparam logic MEM_LOAD_STALL = (LOAD_USE_STALLS >= 2);

  // Shadow copy of the destination tags held by EX, MEM and WB.
  logic          ex_v, mem_v, wb_v;
  logic [AW-1:0] ex_rd, mem_rd, wb_rd;
  logic          ex_l, mem_l;

  logic a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
  logic load_use, stall;

  function automatic logic hit(input logic v, input logic [AW-1:0] rd,
                               input logic [AW-1:0] src, input logic use_bit);
    return v && use_bit && (rd == src) && (rd != '0);
  endfunction

  function automatic logic [1:0] pick(input logic e, input logic m, input logic w);
    if (e)      return 2'b01;
    else if (m) return 2'b10;
    else if (w) return 2'b11;
    else        return 2'b00;
  endfunction

  assign a_ex  = hit(ex_v,  ex_rd,  ID_RA, ID_USE_A);
  assign a_mem = hit(mem_v, mem_rd, ID_RA, ID_USE_A);
  assign a_wb  = hit(wb_v,  wb_rd,  ID_RA, ID_USE_A);
  assign b_ex  = hit(ex_v,  ex_rd,  ID_RB, ID_USE_B);
  assign b_mem = hit(mem_v, mem_rd, ID_RB, ID_USE_B);
  assign b_wb  = hit(wb_v,  wb_rd,  ID_RB, ID_USE_B);

  assign load_use = (ex_l && (a_ex || b_ex)) ||
                    (MEM_LOAD_STALL && mem_l && (a_mem || b_mem));
  // A taken branch squashes the ID instruction, so its hazard must not hold the PC.
  assign stall = load_use && !EX_J;

  always_comb begin
    A_S        = pick(a_ex, a_mem, a_wb);
    B_S        = pick(b_ex, b_mem, b_wb);
    PC_LE      = !stall;
    IFID_LE    = !stall;
    CU_S       = stall || EX_J;
    IFID_FLUSH = EX_J;
    if (!RST) begin
      A_S        = 2'b00;
      B_S        = 2'b00;
      PC_LE      = 1'b1;
      IFID_LE    = 1'b1;
      CU_S       = 1'b0;
      IFID_FLUSH = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ex_v   <= 1'b0;
      ex_rd  <= '0;
      ex_l   <= 1'b0;
      mem_v  <= 1'b0;
      mem_rd <= '0;
      mem_l  <= 1'b0;
      wb_v   <= 1'b0;
      wb_rd  <= '0;
    end else begin
      if (CU_S) begin
        ex_v  <= 1'b0;
        ex_rd <= '0;
        ex_l  <= 1'b0;
      end else begin
        ex_v  <= ID_RF_LE;
        ex_rd <= ID_RD;
        ex_l  <= ID_L;
      end
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      mem_l  <= ex_l;
      wb_v   <= mem_v;
      wb_rd  <= mem_rd;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
      if (EX_J && (flush_cnt != '1))  flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  assign STALL_CNT = stall_cnt;
  assign FLUSH_CNT = flush_cnt;
`else
  assign STALL_CNT = '0;
  assign FLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// tb/tb_hazard_forwarding_unit.sv - self-checking bench for hazard_forwarding_unit
module tb_hazard_forwarding_unit;

  logic        CLK, RST;
  logic [4:0]  ID_RA, ID_RB, ID_RD;
  logic        ID_USE_A, ID_USE_B, ID_RF_LE, ID_L, EX_J;
  logic [1:0]  A_S, B_S, A_S2, B_S2;
  logic        PC_LE, IFID_LE, IFID_FLUSH, CU_S;
  logic        PC_LE2, IFID_LE2, IFID_FLUSH2, CU_S2;
  logic [15:0] STALL_CNT, FLUSH_CNT, STALL_CNT2, FLUSH_CNT2;

  int checks = 0;
  int errors = 0;

  hazard_forwarding_unit #(.AW(5), .LOAD_USE_STALLS(1), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .ID_RA(ID_RA), .ID_RB(ID_RB), .ID_USE_A(ID_USE_A),
    .ID_USE_B(ID_USE_B), .ID_RD(ID_RD), .ID_RF_LE(ID_RF_LE), .ID_L(ID_L), .EX_J(EX_J),
    .A_S(A_S), .B_S(B_S), .PC_LE(PC_LE), .IFID_LE(IFID_LE), .IFID_FLUSH(IFID_FLUSH),
    .CU_S(CU_S), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT));

  hazard_forwarding_unit #(.AW(5), .LOAD_USE_STALLS(2), .CNT_W(16)) dut2 (
    .CLK(CLK), .RST(RST), .ID_RA(ID_RA), .ID_RB(ID_RB), .ID_USE_A(ID_USE_A),
    .ID_USE_B(ID_USE_B), .ID_RD(ID_RD), .ID_RF_LE(ID_RF_LE), .ID_L(ID_L), .EX_J(EX_J),
    .A_S(A_S2), .B_S(B_S2), .PC_LE(PC_LE2), .IFID_LE(IFID_LE2), .IFID_FLUSH(IFID_FLUSH2),
    .CU_S(CU_S2), .STALL_CNT(STALL_CNT2), .FLUSH_CNT(FLUSH_CNT2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0] ra, rb;
    logic       ua, ub;
    logic [4:0] rd;
    logic       le, l, j;
    logic [1:0] a_s, b_s;
    logic       pc, ifid, fl, cu;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int ra, int rb, int ua, int ub, int rd, int le, int l, int j,
                              int a_s, int b_s, int pc, int ifid, int fl, int cu);
    vec_t v;
    v.ra = 5'(ra);  v.rb = 5'(rb);  v.ua = 1'(ua);  v.ub = 1'(ub);
    v.rd = 5'(rd);  v.le = 1'(le);  v.l = 1'(l);    v.j = 1'(j);
    v.a_s = 2'(a_s); v.b_s = 2'(b_s); v.pc = 1'(pc); v.ifid = 1'(ifid);
    v.fl = 1'(fl);  v.cu = 1'(cu);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ID_RA = v.ra; ID_RB = v.rb; ID_USE_A = v.ua; ID_USE_B = v.ub;
    ID_RD = v.rd; ID_RF_LE = v.le; ID_L = v.l; EX_J = v.j;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic nops(input int n);
    for (int k = 0; k < n; k++) begin
      drive(mk(0,0,0,0,0,0,0,0, 0,0,1,1,0,0));
      step();
    end
  endtask

  int exp_stall = 0;
  int exp_flush = 0;

  initial begin
    //      ra rb ua ub rd le l  j   A  B  pc if fl cu
    vecs.push_back(mk(1, 2, 1, 1, 3, 1, 0, 0,  0, 0, 1, 1, 0, 0)); // r3 producer
    vecs.push_back(mk(3, 5, 1, 1, 4, 1, 0, 0,  1, 0, 1, 1, 0, 0)); // back-to-back -> EX
    vecs.push_back(mk(3, 4, 1, 1, 6, 1, 0, 0,  2, 1, 1, 1, 0, 0)); // one gap -> MEM
    vecs.push_back(mk(3, 6, 1, 1, 0, 0, 0, 0,  3, 1, 1, 1, 0, 0)); // two gaps -> WB
    vecs.push_back(mk(3, 4, 1, 1, 0, 0, 0, 0,  0, 3, 1, 1, 0, 0)); // three gaps -> RF
    vecs.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(3, 3, 0, 1, 3, 1, 0, 0,  0, 1, 1, 1, 0, 0)); // use_a=0 gates A
    vecs.push_back(mk(3, 3, 1, 1, 0, 1, 0, 0,  1, 1, 1, 1, 0, 0)); // EX beats MEM
    vecs.push_back(mk(0, 3, 1, 1, 8, 1, 0, 0,  0, 2, 1, 1, 0, 0)); // GR0 never forwarded
    vecs.push_back(mk(1, 0, 1, 0, 7, 1, 1, 0,  0, 0, 1, 1, 0, 0)); // LDW r7
    vecs.push_back(mk(8, 7, 1, 1, 9, 1, 0, 0,  2, 1, 0, 0, 0, 1)); // load-use stall
    vecs.push_back(mk(8, 7, 1, 1, 9, 1, 0, 0,  3, 2, 1, 1, 0, 0)); // re-presented
    vecs.push_back(mk(2, 2, 1, 1,10, 1, 0, 1,  0, 0, 1, 1, 1, 1)); // branch alone
    vecs.push_back(mk(9,10, 1, 1, 0, 0, 0, 0,  2, 0, 1, 1, 0, 0)); // squashed r10 absent
    vecs.push_back(mk(0, 0, 0, 0, 7, 1, 1, 0,  0, 0, 1, 1, 0, 0)); // LDW r7
    vecs.push_back(mk(7, 0, 1, 0,11, 1, 0, 1,  1, 0, 1, 1, 1, 1)); // branch beats stall
    vecs.push_back(mk(7, 0, 1, 0, 0, 0, 0, 0,  2, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 1, 1, 0, 0)); // LDW r0
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0)); // no stall on r0

    RST = 1'b1;
    drive(mk(3, 3, 1, 1, 3, 1, 1, 1, 0, 0, 1, 1, 0, 0));
    #1 RST = 1'b0;
    #1;
    chk("reset.a_s", A_S, 0);
    chk("reset.b_s", B_S, 0);
    chk("reset.pc_le", PC_LE, 1);
    chk("reset.ifid_le", IFID_LE, 1);
    chk("reset.flush", IFID_FLUSH, 0);
    chk("reset.cu_s", CU_S, 0);
    chk("reset.stall_cnt", STALL_CNT, 0);
    chk("reset.flush_cnt", FLUSH_CNT, 0);
    drive(mk(0,0,0,0,0,0,0,0, 0,0,1,1,0,0));
    @(negedge CLK);
    RST = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge CLK);
      chk($sformatf("v%0d.a_s", i), A_S, vecs[i].a_s);
      chk($sformatf("v%0d.b_s", i), B_S, vecs[i].b_s);
      chk($sformatf("v%0d.pc_le", i), PC_LE, vecs[i].pc);
      chk($sformatf("v%0d.ifid_le", i), IFID_LE, vecs[i].ifid);
      chk($sformatf("v%0d.flush", i), IFID_FLUSH, vecs[i].fl);
      chk($sformatf("v%0d.cu_s", i), CU_S, vecs[i].cu);
      if (!vecs[i].pc) exp_stall++;
      if (vecs[i].fl) exp_flush++;
      step();
    end

`ifdef HAZ_PERF_CNT_EN
    chk("cnt.stall", STALL_CNT, exp_stall);
    chk("cnt.flush", FLUSH_CNT, exp_flush);
`else
    chk("cnt.stall_tied", STALL_CNT, 0);
    chk("cnt.flush_tied", FLUSH_CNT, 0);
`endif

    // Two-cycle load-use (registered RAM build)
    nops(3);
    drive(mk(0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 1, 1, 0, 0));
    @(negedge CLK);
    chk("lus2.ld.pc_le", PC_LE2, 1);
    step();
    drive(mk(0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    @(negedge CLK);
    chk("lus2.s1.b_s", B_S2, 2'b01);
    chk("lus2.s1.pc_le", PC_LE2, 0);
    chk("lus2.s1.cu_s", CU_S2, 1);
    step();
    @(negedge CLK);
    chk("lus2.s2.b_s", B_S2, 2'b10);
    chk("lus2.s2.pc_le", PC_LE2, 0);
    chk("lus2.s2.ifid_le", IFID_LE2, 0);
    chk("lus1.s2.b_s", B_S, 2'b10);
    chk("lus1.s2.pc_le", PC_LE, 1);
    step();
    @(negedge CLK);
    chk("lus2.s3.b_s", B_S2, 2'b11);
    chk("lus2.s3.pc_le", PC_LE2, 1);
    chk("lus2.s3.cu_s", CU_S2, 0);
    step();

    // Asynchronous reset in the middle of a stall
    nops(3);
    drive(mk(0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 1, 1, 0, 0));
    step();
    drive(mk(7, 7, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    @(negedge CLK);
    chk("mid.stall.pc_le", PC_LE, 0);
    chk("mid.stall.a_s", A_S, 2'b01);
    #2 RST = 1'b0;
    #1;
    chk("mid.rst.pc_le", PC_LE, 1);
    chk("mid.rst.ifid_le", IFID_LE, 1);
    chk("mid.rst.cu_s", CU_S, 0);
    chk("mid.rst.flush", IFID_FLUSH, 0);
    chk("mid.rst.a_s", A_S, 0);
    chk("mid.rst.b_s", B_S, 0);
    @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge CLK);
      chk($sformatf("post%0d.a_s", k), A_S, 0);
      chk($sformatf("post%0d.b_s", k), B_S, 0);
      chk($sformatf("post%0d.pc_le", k), PC_LE, 1);
      chk($sformatf("post%0d.cu_s", k), CU_S, 0);
    end
    chk("post.stall_cnt", STALL_CNT, 0);
    chk("post.flush_cnt", FLUSH_CNT, 0);
    chk("post.stall_cnt2", STALL_CNT2, 0);
    chk("post.flush_cnt2", FLUSH_CNT2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
